// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multicycle multiply/divide unit: op codes,
// FSM state encoding and the iteration count.
package mult_div_unit_pkg;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = $clog2(ITER);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mult_div_unit_booth.sv
// One radix-2 Booth iteration over {A, Q, q-1}: conditional add/sub of the
// multiplicand into A, then an arithmetic right shift of the whole register.
module booth_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH-1:0] mcand,
   output logic [2*WIDTH:0] next_c
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   // Sum is kept one bit wider so its true sign survives into the shift,
   // which keeps the most-negative multiplicand exact.
   always_comb begin
      a_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
      m_ext = {mcand[WIDTH-1], mcand};
      case (acc[1:0])
         2'b01:   sum = a_ext + m_ext;
         2'b10:   sum = a_ext - m_ext;
         default: sum = a_ext;
      endcase
      next_c = {sum, acc[WIDTH:1]};
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth) / divide (restoring) unit writing HI/LO.
// One bit per cycle; done pulses for one cycle when HI/LO are updated.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] in_regA,
   input  logic [WIDTH-1:0] in_regB,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               op_r;
   logic               dz_r;
   logic [2*WIDTH:0]   acc;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH:0]     dvsr;
   logic               sign_q;
   logic               sign_r;

   logic [2*WIDTH:0]   booth_next_c;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     shifted;
   logic               fits;

   booth_step #(.WIDTH(WIDTH)) u_booth (
      .acc    (acc),
      .mcand  (mcand),
      .next_c (booth_next_c)
   );

   // Operand magnitudes (|-2^31| is 2^31, exact as unsigned) and the
   // restoring-divide trial compare on a WIDTH+1 bit partial remainder.
   always_comb begin
      mag_a   = in_regA[WIDTH-1] ? WIDTH'(-in_regA) : in_regA;
      mag_b   = in_regB[WIDTH-1] ? WIDTH'(-in_regB) : in_regB;
      shifted = {rem, quo[WIDTH-1]};
      fits    = (shifted >= dvsr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_r     <= 1'b0;
         dz_r     <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  cnt  <= '0;
                  busy <= 1'b1;
                  if (op == OP_MULT) begin
                     acc   <= {{WIDTH{1'b0}}, in_regB, 1'b0};
                     mcand <= in_regA;
                     state <= MULT;
                  end else if (in_regB != '0) begin
                     quo    <= mag_a;
                     rem    <= '0;
                     dvsr   <= {1'b0, mag_b};
                     sign_q <= in_regA[WIDTH-1] ^ in_regB[WIDTH-1];
                     sign_r <= in_regA[WIDTH-1];
                     state  <= DIV;
                  end else begin
                     dz_r  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            MULT: begin
               acc <= booth_next_c;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER - 1)) state <= DONE;
            end
            DIV: begin
               rem <= fits ? WIDTH'(shifted - dvsr) : shifted[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], fits};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER - 1)) state <= FIX;
            end
            FIX: begin
               // Quotient truncates toward zero; remainder follows the dividend.
               quo   <= sign_q ? WIDTH'(-quo) : quo;
               rem   <= sign_r ? WIDTH'(-rem) : rem;
               state <= DONE;
            end
            DONE: begin
               done     <= 1'b1;
               div_zero <= dz_r;
               busy     <= 1'b0;
               dz_r     <= 1'b0;
               if (!dz_r) begin
                  if (op_r == OP_MULT) begin
                     hi_out <= acc[2*WIDTH:WIDTH+1];
                     lo_out <= acc[WIDTH:1];
                  end else begin
                     hi_out <= rem;
                     lo_out <= quo;
                  end
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes arithmetic-model
// expectations, an independent monitor pops them on every done pulse.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] in_regA = '0;
   logic [31:0] in_regB = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi_out, lo_out;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          edge_cnt = 0;
   logic [31:0] model_hi = '0, model_lo = '0;
   logic [31:0] shown_hi = '0, shown_lo = '0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .in_regA  (in_regA),
      .in_regB  (in_regB),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Reference: plain signed arithmetic, independent of any iteration scheme.
   task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b, input int s);
      exp_t   e;
      longint p;
      int     sa, sb_;
      sa = a;
      sb_ = b;
      e.dz = 1'b0;
      if (o == 1'b0) begin
         p = longint'(sa) * longint'(sb_);
         e.hi = p[63:32];
         e.lo = p[31:0];
         e.due = s + 33;
      end else if (b == 32'd0) begin
         e.hi = model_hi;
         e.lo = model_lo;
         e.dz = 1'b1;
         e.due = s + 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.hi = 32'd0;
         e.lo = 32'h8000_0000;
         e.due = s + 34;
      end else begin
         e.lo = sa / sb_;
         e.hi = sa % sb_;
         e.due = s + 34;
      end
      model_hi = e.hi;
      model_lo = e.lo;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   // Issue one operation; operands are scrambled right after the start edge.
   task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input bit wait_done);
      @(negedge clk);
      start = 1'b1;
      op = o;
      in_regA = a;
      in_regB = b;
      model(o, a, b, edge_cnt + 1);
      @(negedge clk);
      start = 1'b0;
      op = 1'($urandom);
      in_regA = $urandom;
      in_regB = $urandom;
      chk("busy_after_start", 64'(busy), 64'd1);
      if (wait_done) wait_idle();
   endtask

   // Monitor: pops on done, verifies hold of HI/LO while busy.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            shown_hi = '0;
            shown_lo = '0;
         end else if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pulse (edge %0d)", edge_cnt);
            end else begin
               e = sb.pop_front();
               chk("hi_out", 64'(hi_out), 64'(e.hi));
               chk("lo_out", 64'(lo_out), 64'(e.lo));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
               chk("done_edge", 64'(edge_cnt), 64'(e.due));
               chk("busy_at_done", 64'(busy), 64'd0);
               shown_hi = hi_out;
               shown_lo = lo_out;
            end
         end else begin
            if (div_zero) begin
               checks++;
               errors++;
               $display("FAIL div_zero_alone: got 1 expected 0 without done");
            end
            if (busy) begin
               chk("hold_hi", 64'(hi_out), 64'(shown_hi));
               chk("hold_lo", 64'(lo_out), 64'(shown_lo));
            end
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      logic        o;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_lo", 64'(lo_out), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Reset mid-mult: aborted op produces no result and no done pulse.
      start = 1'b1; op = 1'b0; in_regA = 32'd7; in_regB = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi_out), 64'd0);
      chk("abort_lo", 64'(lo_out), 64'd0);
      model_hi = '0;
      model_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      issue(1'b0, 32'd3, 32'd4, 1'b1);

      // Directed corners.
      issue(1'b0, 32'hFFFF_FFFE, 32'd3, 1'b1);
      issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
      issue(1'b1, 32'h0000_0451, 32'h20, 1'b1);
      issue(1'b1, 32'd5, 32'd0, 1'b1);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      issue(1'b1, 32'h8000_0000, 32'd1, 1'b1);

      // Start while busy is ignored: exactly one done, product 42.
      issue(1'b0, 32'd6, 32'd7, 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 1'b1; in_regA = 32'd100; in_regB = 32'd10;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (40) @(negedge clk);

      // Randomized mix.
      for (int i = 0; i < 40; i++) begin
         o = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       a = 32'($urandom_range(0, 200)) - 32'd100;
            1:       a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(0, 20)) - 32'd10;
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         issue(o, a, b, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS-style datapath. Sits beside the ALU, downstream of the register A/B operand registers that also feed the ALU source muxes.
- Operands are taken from regA/regB on a start pulse from the control FSM. The unit iterates one bit per cycle and writes the HI/LO result registers.
- The control FSM waits on done before reading HI/LO (mfhi/mflo paths).

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; clears all state
- start  in  1  one-cycle request; operands and op are sampled on the same edge
- op  in  1  0 = signed multiply (mult), 1 = signed divide (div)
- in_regA  in  WIDTH  multiplicand / dividend
- in_regB  in  WIDTH  multiplier / divisor
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi_out/lo_out are updated
- div_zero  out  1  one-cycle pulse, coincident with done, for a divide by zero
- hi_out  out  WIDTH  HI register: product[63:32], or remainder
- lo_out  out  WIDTH  LO register: product[31:0], or quotient

Behaviour:
- Reset (reset = 0, async): state = IDLE; busy, done, div_zero, hi_out, lo_out, counter and internal registers all = 0.
- FSM states: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - start = 1 and op = 0: latch operands, go to MULT, counter = 0.
  - start = 1, op = 1, in_regB != 0: latch operands, go to DIV.
  - start = 1, op = 1, in_regB == 0: go to DONE with div_zero flagged.
- MULT:
  - Radix-2 Booth, one step per cycle over a {A, Q, q-1} register of 2*WIDTH+1 bits, with arithmetic right shift.
  - 32 cycles, then go to DONE.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle.
  - 32 cycles, then go to FIX.
- FIX (one cycle):
  - Quotient negated if the operand signs differ; truncation is toward zero.
  - Remainder negated if the dividend is negative; the remainder takes the dividend's sign.
- DONE (one cycle):
  - hi_out/lo_out are loaded, done = 1, then return to IDLE.
  - On divide by zero, hi_out/lo_out keep their previous values and div_zero = 1 with done.
- Latency, counting edge 0 as the edge that samples start:
  - mult: done high in cycle 34 (results visible after edge 33).
  - div: done high in cycle 35.
  - div by zero: done high in cycle 2.
- busy is high from the cycle after the start edge through the DONE cycle inclusive, and low in IDLE.
- start while busy is ignored; no queuing, and operands are not re-sampled.
- Operand changes on in_regA/in_regB after the start edge have no effect.
- hi_out/lo_out change only in the DONE cycle and hold otherwise, including while busy.
- Overflow case -2^31 / -1: lo_out = 0x80000000, hi_out = 0. No exception is raised.
- Magnitude of -2^31 is handled in WIDTH+1 bits, so no overflow occurs internally.
- Reset asserted mid-operation: the operation aborts immediately, outputs return to 0 and no done pulse is issued.
- op is only meaningful on the start edge.

Decomposition:
- Shared package (control-unit constants include file):
  - OP_MULT = 1'b0, OP_DIV = 1'b1.
  - FSM state encodings, 3 bits: IDLE = 0, MULT = 1, DIV = 2, FIX = 3, DONE = 4.
  - ITER = 32.
- One natural sub-module, booth_step: combinational single Booth iteration (add/sub/none plus arithmetic shift).
- The divide datapath stays inline in mult_div_unit.

Test Plan:
- Reset mid-mult: start mult 7 x 9, assert reset at cycle 10 -> busy = 0, hi_out = lo_out = 0, no done pulse; a new mult 3 x 4 then gives lo_out = 12, hi_out = 0.
- Signed mult: A = 0xFFFFFFFE (-2), B = 0x00000003 -> done in cycle 34; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFFA. Also A = B = 0x80000000 -> hi_out = 0x40000000, lo_out = 0.
- Signed div: A = -7, B = 2 -> lo_out = 0xFFFFFFFD (-3), hi_out = 0xFFFFFFFF (-1), done in cycle 35. Also A = 7, B = -2 -> lo_out = -3, hi_out = 1.
- Divide by zero: previous hi_out/lo_out = 0x11/0x22; div A = 5, B = 0 -> done and div_zero pulse in cycle 2; hi_out/lo_out stay 0x11/0x22.
- Overflow div: A = 0x80000000, B = 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0.
- start while busy: second start (div 100/10) at cycle 5 of mult 6 x 7 -> ignored; lo_out = 42; busy drops after the DONE cycle; exactly one done pulse.
